rv_muldiv_unit: RTL and testbench

RV32M execute-stage arithmetic block with two independent engines that share one issue interface.
- A 2-stage pipelined multiplier handles MUL, MULH, MULHSU and MULHU.
- An iterative radix-2 restoring divider handles DIV, DIVU, REM and REMU.
- Both engines receive the same issue signals. funct3_i[2] selects which engine accepts the operation.
- Both engines report the destination register so the core can do hazard checks and writeback.

---
 rtl/rv_muldiv_unit_if.sv | 41 ++++
 rtl/rv_muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rv_muldiv_unit_if.sv
// Issue bus and result signals shared by the RV32M multiply/divide unit.
// The core drives the master side; the unit sits on the slave side.
interface rv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic            valid_i;
    logic            flush_i;
    logic            stall_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      rd_i;
    logic            mul_rd_stage1_valid_o;
    logic [4:0]      mul_rd_stage1_o;
    logic            mul_rd_stage2_valid_o;
    logic [4:0]      mul_rd_stage2_o;
    logic [XLEN-1:0] mul_result_o;
    logic            div_ready_o;
    logic            div_busy_o;
    logic [4:0]      div_rd_o;
    logic [XLEN-1:0] div_result_o;

    modport slave (
        input  start_i, valid_i, flush_i, stall_i,
        input  funct3_i, rs1_i, rs2_i, rd_i,
        output mul_rd_stage1_valid_o, mul_rd_stage1_o,
        output mul_rd_stage2_valid_o, mul_rd_stage2_o,
        output mul_result_o,
        output div_ready_o, div_busy_o, div_rd_o, div_result_o
    );

    modport master (
        output start_i, valid_i, flush_i, stall_i,
        output funct3_i, rs1_i, rs2_i, rd_i,
        input  mul_rd_stage1_valid_o, mul_rd_stage1_o,
        input  mul_rd_stage2_valid_o, mul_rd_stage2_o,
        input  mul_result_o,
        input  div_ready_o, div_busy_o, div_rd_o, div_result_o
    );
endinterface

// File: rtl/rv_muldiv_unit.sv
// RV32M execute block: 2-stage pipelined multiplier plus an
// iterative radix-2 restoring divider behind one issue port.
module rv_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic              clk,
    input  logic              rst,
    rv_muldiv_unit_if.slave   bus
);
    localparam int CW = $clog2(DIV_ITERS + 1);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic w_issue, w_mul_issue, w_div_issue;
    assign w_issue = bus.start_i & bus.valid_i
                   & ~bus.stall_i & ~bus.flush_i;
    assign w_mul_issue = w_issue & ~bus.funct3_i[2];
    assign w_div_issue = w_issue & bus.funct3_i[2];

    logic            r_m1_valid, r_m1_asgn, r_m1_bsgn, r_m1_hi;
    logic [4:0]      r_m1_rd;
    logic [XLEN-1:0] r_m1_a, r_m1_b;
    logic            r_m2_valid;
    logic [4:0]      r_m2_rd;
    logic [XLEN-1:0] r_m2_result;

    logic signed [XLEN:0]     w_a_ext, w_b_ext;
    logic signed [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]          w_mul_sel;

    // 33-bit extension makes one signed multiply cover all four ops
    always_comb begin
        w_a_ext   = {r_m1_asgn & r_m1_a[XLEN-1], r_m1_a};
        w_b_ext   = {r_m1_bsgn & r_m1_b[XLEN-1], r_m1_b};
        w_prod    = w_a_ext * w_b_ext;
        w_mul_sel = r_m1_hi ? w_prod[2*XLEN-1:XLEN]
                            : w_prod[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m1_valid  <= 1'b0;
            r_m1_asgn   <= 1'b0;
            r_m1_bsgn   <= 1'b0;
            r_m1_hi     <= 1'b0;
            r_m1_rd     <= '0;
            r_m1_a      <= '0;
            r_m1_b      <= '0;
            r_m2_valid  <= 1'b0;
            r_m2_rd     <= '0;
            r_m2_result <= '0;
        end else if (bus.flush_i) begin
            r_m1_valid <= 1'b0;
            r_m2_valid <= 1'b0;
        end else if (!bus.stall_i) begin
            r_m1_valid <= w_mul_issue;
            if (w_mul_issue) begin
                r_m1_a    <= bus.rs1_i;
                r_m1_b    <= bus.rs2_i;
                r_m1_rd   <= bus.rd_i;
                r_m1_asgn <= ~(bus.funct3_i[1] & bus.funct3_i[0]);
                r_m1_bsgn <= ~bus.funct3_i[1];
                r_m1_hi   <= bus.funct3_i[1] | bus.funct3_i[0];
            end
            r_m2_valid <= r_m1_valid;
            if (r_m1_valid) begin
                r_m2_rd     <= r_m1_rd;
                r_m2_result <= w_mul_sel;
            end
        end
    end

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_quo, r_rem, r_dvs;
    logic            r_neg_q, r_neg_r, r_is_rem, r_div0;
    logic [4:0]      r_rd;
    logic            r_ready;
    logic [4:0]      r_div_rd;
    logic [XLEN-1:0] r_div_result;

    logic            w_a_neg, w_b_neg;
    logic [XLEN:0]   w_shift, w_sub;
    logic [XLEN-1:0] w_q_fix, w_r_fix;

    always_comb begin
        w_a_neg = ~bus.funct3_i[0] & bus.rs1_i[XLEN-1];
        w_b_neg = ~bus.funct3_i[0] & bus.rs2_i[XLEN-1];
        w_shift = {r_rem, r_quo[XLEN-1]};
        w_sub   = w_shift - {1'b0, r_dvs};
        // divide-by-zero quotient is all ones regardless of dividend sign
        w_q_fix = r_div0  ? '1
                : r_neg_q ? -r_quo : r_quo;
        w_r_fix = r_neg_r ? -r_rem : r_rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_quo        <= '0;
            r_rem        <= '0;
            r_dvs        <= '0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_is_rem     <= 1'b0;
            r_div0       <= 1'b0;
            r_rd         <= '0;
            r_ready      <= 1'b0;
            r_div_rd     <= '0;
            r_div_result <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: if (w_div_issue) begin
                    r_quo    <= w_a_neg ? -bus.rs1_i : bus.rs1_i;
                    r_dvs    <= w_b_neg ? -bus.rs2_i : bus.rs2_i;
                    r_rem    <= '0;
                    r_neg_q  <= w_a_neg ^ w_b_neg;
                    r_neg_r  <= w_a_neg;
                    r_is_rem <= bus.funct3_i[1];
                    r_div0   <= (bus.rs2_i == '0);
                    r_rd     <= bus.rd_i;
                    r_cnt    <= CW'(DIV_ITERS);
                    r_state  <= S_BUSY;
                end
                S_BUSY: if (bus.flush_i) begin
                    r_state <= S_IDLE;
                end else begin
                    if (!w_sub[XLEN]) begin
                        r_rem <= w_sub[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) r_state <= S_DONE;
                end
                S_DONE: begin
                    if (!bus.flush_i) begin
                        r_div_result <= r_is_rem ? w_r_fix : w_q_fix;
                        r_div_rd     <= r_rd;
                        r_ready      <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mul_rd_stage1_valid_o = r_m1_valid;
    assign bus.mul_rd_stage1_o       = r_m1_rd;
    assign bus.mul_rd_stage2_valid_o = r_m2_valid;
    assign bus.mul_rd_stage2_o       = r_m2_rd;
    assign bus.mul_result_o          = r_m2_result;
    assign bus.div_ready_o           = r_ready;
    assign bus.div_busy_o            = (r_state != S_IDLE);
    assign bus.div_rd_o              = r_div_rd;
    assign bus.div_result_o          = r_div_result;
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Scoreboard bench for rv_muldiv_unit: directed ops push expected
// results, a negedge monitor pops them as the unit reports completions.
module tb_rv_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;

    exp_t mq[$];
    exp_t dq[$];
    exp_t me, de;
    logic [31:0] last_div;
    logic [4:0]  last_rd;

    rv_muldiv_unit_if #(.XLEN(32)) bus ();

    rv_muldiv_unit #(.XLEN(32), .DIV_ITERS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mul_rd_stage2_valid_o) begin
                if (mq.size() == 0) begin
                    chk("mul_unexpected", 32'd1, 32'd0);
                end else begin
                    me = mq.pop_front();
                    chk("mul_cycle", cyc, me.cyc);
                    chk("mul_rd", {27'd0, bus.mul_rd_stage2_o}, {27'd0, me.rd});
                    chk("mul_result", bus.mul_result_o, me.res);
                end
            end
            if (bus.div_ready_o) begin
                if (dq.size() == 0) begin
                    chk("div_unexpected", 32'd1, 32'd0);
                end else begin
                    de = dq.pop_front();
                    chk("div_cycle", cyc, de.cyc);
                    chk("div_rd", {27'd0, bus.div_rd_o}, {27'd0, de.rd});
                    chk("div_result", bus.div_result_o, de.res);
                    chk("div_busy_drop", {31'd0, bus.div_busy_o}, 32'd0);
                end
            end
        end
    end

    // Called at a negedge; issues for one edge, optionally scoreboards it
    task automatic op(input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd,
                      input logic [31:0] exp, input bit push,
                      input int extra);
        exp_t e;
        bus.start_i  = 1'b1;
        bus.valid_i  = 1'b1;
        bus.funct3_i = f3;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        bus.rd_i     = rd;
        if (push) begin
            e.cyc = cyc + (f3[2] ? 34 : 2) + extra;
            e.rd  = rd;
            e.res = exp;
            if (f3[2]) dq.push_back(e);
            else mq.push_back(e);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.valid_i = 1'b0;
    endtask

    task automatic div_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp);
        op(f3, a, b, rd, exp, 1'b1, 0);
        repeat (35) @(negedge clk);
        last_div = exp;
        last_rd  = rd;
    endtask

    initial begin
        bus.start_i  = 1'b0;
        bus.valid_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.stall_i  = 1'b0;
        bus.funct3_i = 3'd0;
        bus.rs1_i    = '0;
        bus.rs2_i    = '0;
        bus.rd_i     = '0;
        repeat (3) @(negedge clk);
        chk("rst_s1_valid", {31'd0, bus.mul_rd_stage1_valid_o}, 32'd0);
        chk("rst_s2_valid", {31'd0, bus.mul_rd_stage2_valid_o}, 32'd0);
        chk("rst_mul_result", bus.mul_result_o, 32'd0);
        chk("rst_div_busy", {31'd0, bus.div_busy_o}, 32'd0);
        chk("rst_div_ready", {31'd0, bus.div_ready_o}, 32'd0);
        chk("rst_div_result", bus.div_result_o, 32'd0);
        chk("rst_div_rd", {27'd0, bus.div_rd_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // first division, with an ignored issue while busy
        op(3'b100, 32'd100, 32'd4, 5'd2, 32'd25, 1'b1, 0);
        chk("div_busy_iter", {31'd0, bus.div_busy_o}, 32'd1);
        op(3'b100, 32'd1, 32'd1, 5'd7, 32'd1, 1'b0, 0);
        repeat (34) @(negedge clk);
        div_op(3'b100, 32'd32, 32'd4, 5'd3, 32'd8);
        div_op(3'b110, 32'd119, 32'd6, 5'd4, 32'd5);
        div_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD);
        div_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF);
        div_op(3'b101, 32'hFFFFFFFF, 32'd2, 5'd7, 32'h7FFFFFFF);
        div_op(3'b100, 32'd9, 32'd0, 5'd8, 32'hFFFFFFFF);
        div_op(3'b100, 32'hFFFFFFF7, 32'd0, 5'd9, 32'hFFFFFFFF);
        div_op(3'b110, 32'd5, 32'd0, 5'd10, 32'd5);
        div_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000);
        div_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0);
        div_op(3'b111, 32'd100, 32'd7, 5'd13, 32'd2);
        div_op(3'b110, 32'd7, 32'hFFFFFFFE, 5'd14, 32'd1);

        // multiplier vectors, issued back to back
        op(3'b000, 32'd7, 32'd6, 5'd9, 32'd42, 1'b1, 0);
        op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'd0, 1'b1, 0);
        op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'hFFFFFFFE, 1'b1, 0);
        op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFF, 1'b1, 0);
        op(3'b000, 32'h00010000, 32'h00010000, 5'd13, 32'd0, 1'b1, 0);
        op(3'b001, 32'h00010000, 32'h00010000, 5'd14, 32'd1, 1'b1, 0);
        op(3'b001, 32'h80000000, 32'h80000000, 5'd15, 32'h40000000, 1'b1, 0);
        op(3'b010, 32'h80000000, 32'd2, 5'd16, 32'hFFFFFFFF, 1'b1, 0);
        op(3'b000, 32'hFFFFFFFD, 32'd5, 5'd17, 32'hFFFFFFF1, 1'b1, 0);
        repeat (4) @(negedge clk);

        // stall with a MUL in stage 1; the stalled issue must be dropped
        op(3'b000, 32'd3, 32'd4, 5'd18, 32'd12, 1'b1, 3);
        bus.stall_i  = 1'b1;
        bus.start_i  = 1'b1;
        bus.valid_i  = 1'b1;
        bus.rd_i     = 5'd19;
        repeat (3) begin
            @(negedge clk);
            chk("stall_s1_valid", {31'd0, bus.mul_rd_stage1_valid_o}, 32'd1);
            chk("stall_s1_rd", {27'd0, bus.mul_rd_stage1_o}, 32'd18);
            chk("stall_s2_valid", {31'd0, bus.mul_rd_stage2_valid_o}, 32'd0);
        end
        bus.stall_i = 1'b0;
        bus.start_i = 1'b0;
        bus.valid_i = 1'b0;
        repeat (4) @(negedge clk);

        // flush a MUL in stage 1
        op(3'b000, 32'd5, 32'd5, 5'd20, 32'd25, 1'b0, 0);
        chk("flush_s1_before", {31'd0, bus.mul_rd_stage1_valid_o}, 32'd1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush_s1_after", {31'd0, bus.mul_rd_stage1_valid_o}, 32'd0);
        repeat (4) @(negedge clk);

        // flush a division ten cycles in
        op(3'b100, 32'd1000, 32'd3, 5'd21, 32'd333, 1'b0, 0);
        repeat (9) @(negedge clk);
        chk("flush_div_busy_before", {31'd0, bus.div_busy_o}, 32'd1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush_div_busy_after", {31'd0, bus.div_busy_o}, 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_div_hold_result", bus.div_result_o, last_div);
        chk("flush_div_hold_rd", {27'd0, bus.div_rd_o}, {27'd0, last_rd});

        // flush beats a simultaneous issue; stall blocks issue
        bus.flush_i = 1'b1;
        op(3'b101, 32'd9, 32'd3, 5'd22, 32'd3, 1'b0, 0);
        bus.flush_i = 1'b0;
        chk("flush_issue_div", {31'd0, bus.div_busy_o}, 32'd0);
        bus.stall_i = 1'b1;
        op(3'b101, 32'd9, 32'd3, 5'd23, 32'd3, 1'b0, 0);
        bus.stall_i = 1'b0;
        chk("stall_issue_div", {31'd0, bus.div_busy_o}, 32'd0);
        bus.flush_i = 1'b1;
        op(3'b000, 32'd2, 32'd2, 5'd24, 32'd4, 1'b0, 0);
        bus.flush_i = 1'b0;
        chk("flush_issue_mul", {31'd0, bus.mul_rd_stage1_valid_o}, 32'd0);

        // division after a flush still works
        div_op(3'b101, 32'd1000, 32'd3, 5'd25, 32'd333);
        repeat (5) @(negedge clk);
        chk("mul_pending", mq.size(), 32'd0);
        chk("div_pending", dq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
